fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Small instruction buffer between the Fetch stage and Decode.
- Captures each fetched {PC+4, instruction} pair when the instruction cache reports a hit, and presents pairs to Decode in order through a valid/ready handshake.
- Back-pressures Fetch when full.
- Discards all buffered work on a taken-branch flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width, equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- inValid  input  1  Fetch has a valid instruction this cycle; driven by the cache hitBit.
- inPC  input  32  Fetch nextPC (PC+4 of the instruction).
- inInstr  input  32  fetched instruction word.
- inReady  output  1  queue can accept; low means Fetch must hold the PC.
- flush  input  1  taken branch (PCSrc); discard all contents.
- outValid  output  1  head entry is valid for Decode.
- outPC  output  32  PC+4 of the head entry.
- outInstr  output  32  instruction of the head entry.
- outReady  input  1  Decode consumes the head this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH x 64-bit register array, plus wrPtr and rdPtr (AW bits, wrap modulo DEPTH) and count (AW+1 bits).
  - Full is count==DEPTH; empty is count==0.
- Reset (rst_n low at a rising edge):
  - wrPtr=0, rdPtr=0, count=0.
  - Outputs: outValid=0, outPC=0, outInstr=0, inReady=1.
  - Array contents are don't-care.
  - Reset overrides flush, push and pop in the same cycle.
  - Reset mid-operation drops every entry; the first push after reset lands in entry 0.
- inReady = !full. It is combinational from count only and never depends on inValid or outReady.
- Push:
  - Occurs when inValid && inReady && !flush.
  - Writes {inPC, inInstr} at wrPtr; wrPtr increments and wraps DEPTH-1 to 0.
  - Written data is visible at the head no earlier than the next cycle; there is no same-cycle bypass.
- Pop:
  - Occurs when outValid && outReady && !flush; rdPtr increments and wraps.
  - outReady while outValid=0 has no effect.
- Count update:
  - Push only: +1. Pop only: -1. Both: unchanged.
  - Push and pop are both legal when 0<count<DEPTH.
  - When full, no push is possible, so a pop alone decrements count.
  - When empty, no pop is possible.
- Output view:
  - outValid = (count!=0). Show-ahead: outPC and outInstr are taken directly from array[rdPtr].
  - When empty, outPC=0 and outInstr=0 (NOP), so Decode sees a bubble.
  - Outputs are stable while outValid=1 and outReady=0.
- Flush:
  - At the rising edge with flush=1: wrPtr=0, rdPtr=0, count=0.
  - Any push or pop presented in that cycle is discarded.
  - Next cycle: outValid=0, inReady=1.
  - Flush has priority over push and pop; reset has priority over flush.
- Cache miss: inValid=0 while the cache refills; the queue simply drains toward Decode, with no special state.
- Latency: 1 cycle from an accepted push to outValid when previously empty.
- Throughput: 1 instruction per cycle sustained when Decode is always ready.
- Invariants:
  - count equals (wrPtr-rdPtr) mod DEPTH, except that DEPTH is distinguished by count.
  - count never exceeds DEPTH and never underflows.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with inValid=1 and flush=1 -> count=0, outValid=0, outInstr=0x00000000, inReady=1 after the release edge.
- Fill and stall: push 0x20080001..0x20080004 with PCs 0x04..0x10 and outReady=0 -> count goes 1,2,3,4; inReady=0 after the 4th push. A 5th inValid with 0x20080005 is not stored; the head stays 0x20080001/PC 0x04.
- Streaming with wrap: outReady=1 and inValid=1 for 10 cycles with instructions 0x100..0x109 -> outInstr sequence 0x100..0x109, each one cycle after its push; count stays 1; pointers wrap twice with no loss or duplication.
- Simultaneous push and pop at count=2 -> count stays 2; order preserved; the new entry appears after the two older ones.
- Flush: with count=3, assert flush together with inValid (0xDEADBEEF) and outReady -> next cycle count=0, outValid=0. The next push 0x8C090000 at PC 0x40 appears as the head one cycle later.
- Miss gap: inValid=0 for 5 cycles mid-stream with outReady=1 -> the queue drains to empty; outValid=0 and outInstr=0 during the gap; instructions resume in order afterwards.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction buffer between Fetch and Decode: captures {PC+4, instr}
// pairs on a cache hit and offers them to Decode in show-ahead valid/ready form.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inValid,
    input  logic [31:0]   inPC,
    input  logic [31:0]   inInstr,
    output logic          inReady,
    input  logic          flush,
    output logic          outValid,
    output logic [31:0]   outPC,
    output logic [31:0]   outInstr,
    input  logic          outReady,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = inValid && !full && !flush;
    assign pop   = !empty && outReady && !flush;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) wrPtr_d = wrPtr_q + AW'(1);
            if (pop)  rdPtr_d = rdPtr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Array contents need no reset; the empty flag masks stale data at the outputs.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wrPtr_q] <= {inPC, inInstr};
        end
    end

    assign inReady  = !full;
    assign outValid = !empty;
    assign outPC    = empty ? 32'h0 : mem_q[rdPtr_q][63:32];
    assign outInstr = empty ? 32'h0 : mem_q[rdPtr_q][31:0];
    assign count    = count_q;

endmodule
